// File: rtl/capture_pkg.sv
// Shared definitions for the photo capture path: FSM state encoding and
// the default frame size (640x480).
package capture_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ARM     = 3'd1,
      S_CAPTURE = 3'd2,
      S_DRAIN   = 3'd3,
      S_DONE    = 3'd4
   } capture_state_t;

   localparam int DEFAULT_FRAME_PIXELS = 307200;

endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO between the pixel strobe and the memory writer.
// DEPTH must be a power of two; the head word is visible combinationally.
module pixel_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/photo_capture.sv
// Captures one camera frame into memory after a ready request: pixels are
// buffered in a small FIFO and written to consecutive (packed) addresses.
module photo_capture
   import capture_pkg::*;
#(
   parameter int              FRAME_PIXELS = DEFAULT_FRAME_PIXELS,
   parameter int              ADDR_W       = 20,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
   parameter int              FIFO_DEPTH   = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              ready,
   input  logic              sof,
   input  logic              pix_valid,
   input  logic [15:0]       pix_data,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_data,
   input  logic              mem_ack,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic              short_frame,
   output logic [2:0]        state_dbg
);

   localparam int               CNT_W      = $clog2(FRAME_PIXELS + 1);
   localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_PIXELS - 1);

   capture_state_t   state;
   logic [CNT_W-1:0] pix_count;
   logic             fifo_push;
   logic             fifo_pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [15:0]      fifo_head;
   logic             writer_active;

   // Handshake: mem_wr/mem_addr/mem_data form a valid-style request that is
   // held until mem_ack; a cycle with mem_wr=1 and mem_ack=1 transfers one
   // word. mem_ack with mem_wr=0 has no effect.
   assign writer_active = (state == S_ARM) || (state == S_CAPTURE) || (state == S_DRAIN);
   assign mem_wr        = writer_active && !fifo_empty;
   assign mem_data      = mem_wr ? fifo_head : 16'h0000;
   assign fifo_pop      = mem_wr && mem_ack;
   assign fifo_push     = (state == S_CAPTURE) && pix_valid && !sof;

   assign busy      = (state != S_IDLE);
   assign done      = (state == S_DONE);
   assign state_dbg = state;

   pixel_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (16)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (fifo_push),
      .wr_data (pix_data),
      .pop     (fifo_pop),
      .rd_data (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         pix_count   <= '0;
         mem_addr    <= BASE_ADDR;
         overflow    <= 1'b0;
         short_frame <= 1'b0;
      end else begin
         // Address only advances on an accepted write, so dropped pixels cost nothing.
         if (fifo_pop) mem_addr <= mem_addr + ADDR_W'(1);

         case (state)
            S_IDLE: begin
               if (ready) begin
                  state       <= S_ARM;
                  pix_count   <= '0;
                  mem_addr    <= BASE_ADDR;
                  overflow    <= 1'b0;
                  short_frame <= 1'b0;
               end
            end
            S_ARM: begin
               if (sof) state <= S_CAPTURE;
            end
            S_CAPTURE: begin
               if (sof) begin
                  short_frame <= 1'b1;
                  state       <= S_DRAIN;
               end else if (pix_valid) begin
                  pix_count <= pix_count + 1'b1;
                  if (fifo_full) overflow <= 1'b1;
                  if (pix_count == FRAME_LAST) state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (fifo_empty) state <= S_DONE;
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_photo_capture.sv
// Directed bench for photo_capture with an 8-pixel frame, 4-entry FIFO and
// base address 0x100.
module tb_photo_capture;
   import capture_pkg::*;

   localparam int          FP   = 8;
   localparam int          AW   = 20;
   localparam int          FD   = 4;
   localparam logic [19:0] BASE = 20'h100;
   localparam int          W    = 36;

   logic        clk;
   logic        reset_n;
   logic        ready;
   logic        sof;
   logic        pix_valid;
   logic [15:0] pix_data;
   logic        mem_wr;
   logic [19:0] mem_addr;
   logic [15:0] mem_data;
   logic        mem_ack;
   logic        busy;
   logic        done;
   logic        overflow;
   logic        short_frame;
   logic [2:0]  state_dbg;

   photo_capture #(
      .FRAME_PIXELS (FP),
      .ADDR_W       (AW),
      .BASE_ADDR    (BASE),
      .FIFO_DEPTH   (FD)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .ready       (ready),
      .sof         (sof),
      .pix_valid   (pix_valid),
      .pix_data    (pix_data),
      .mem_wr      (mem_wr),
      .mem_addr    (mem_addr),
      .mem_data    (mem_data),
      .mem_ack     (mem_ack),
      .busy        (busy),
      .done        (done),
      .overflow    (overflow),
      .short_frame (short_frame),
      .state_dbg   (state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_cmp  = 0;
   int          n_fail = 0;
   int          done_cnt = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] got_q[$];
   logic        prev_stall = 1'b0;
   logic [19:0] prev_addr;
   logic [15:0] prev_data;

   // write monitor and handshake-hold check, sampled mid-cycle
   always @(negedge clk) begin
      if (!reset_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            n_cmp++;
            if (mem_wr !== 1'b1 || mem_addr !== prev_addr || mem_data !== prev_data) begin
               n_fail++;
               $display("FAIL hold: wr=%b addr=%h data=%h, required wr=1 addr=%h data=%h",
                        mem_wr, mem_addr, mem_data, prev_addr, prev_data);
            end
         end
         if (mem_wr === 1'b1 && mem_ack === 1'b1) got_q.push_back({mem_addr, mem_data});
         if (done === 1'b1) done_cnt++;
         prev_stall = (mem_wr === 1'b1 && mem_ack === 1'b0);
         prev_addr  = mem_addr;
         prev_data  = mem_data;
      end
   end

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame();
      ready = 1'b1;
      step();
      ready = 1'b0;
      sof = 1'b1;
      step();
      sof = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int c = 0;
      while (done_cnt == 0 && c < budget) begin
         step();
         c++;
      end
      repeat (3) step();
   endtask

   task automatic clear_sb();
      done_cnt = 0;
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_reset();
      reset_n = 1'b0; ready = 1'b0; sof = 1'b0; pix_valid = 1'b0;
      pix_data = 16'h0; mem_ack = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({mem_wr, busy, done, overflow, short_frame} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_flags: wr/busy/done/ovf/short=%b, required 00000",
                  {mem_wr, busy, done, overflow, short_frame});
      end
      n_cmp++;
      if (mem_addr !== BASE || mem_data !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_bus: addr=%h data=%h, required addr=%h data=0000", mem_addr, mem_data, BASE);
      end
      n_cmp++;
      if (state_dbg !== 3'(S_IDLE)) begin
         n_fail++;
         $display("FAIL reset_state: state=%0d, required %0d", state_dbg, 3'(S_IDLE));
      end
      reset_n = 1'b1;
      step();
   endtask

   task automatic test_nominal();
      clear_sb();
      mem_ack = 1'b1;
      start_frame();
      for (int i = 0; i < FP; i++) begin
         pix_valid = 1'b1;
         pix_data  = 16'(i + 1);
         if (i == 1) begin
            @(negedge clk);
            n_cmp++;
            if (mem_wr !== 1'b1 || mem_data !== 16'h1 || mem_addr !== BASE) begin
               n_fail++;
               $display("FAIL nominal_latency: wr=%b addr=%h data=%h, required wr=1 addr=%h data=0001",
                        mem_wr, mem_addr, mem_data, BASE);
            end
         end
         step();
      end
      pix_valid = 1'b0;
      wait_done(100);
      for (int i = 0; i < FP; i++) exp_q.push_back({BASE + 20'(i), 16'(i + 1)});
      n_cmp++;
      if (got_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL nominal_count: writes=%0d, required %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         n_cmp++;
         if (got_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL nominal_write%0d: got %h, required %h", i, got_q[i], exp_q[i]);
         end
      end
      n_cmp++;
      if (done_cnt != 1 || overflow !== 1'b0 || short_frame !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL nominal_end: done_pulses=%0d ovf=%b short=%b busy=%b, required 1 0 0 0",
                  done_cnt, overflow, short_frame, busy);
      end
   endtask

   task automatic test_backpressure();
      clear_sb();
      mem_ack = 1'b0;
      start_frame();
      for (int i = 0; i < FP; i++) begin
         pix_valid = 1'b1;
         pix_data  = 16'(i + 1);
         step();
      end
      pix_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (overflow !== 1'b1 || state_dbg !== 3'(S_DRAIN)) begin
         n_fail++;
         $display("FAIL bp_overflow: ovf=%b state=%0d, required ovf=1 state=%0d",
                  overflow, state_dbg, 3'(S_DRAIN));
      end
      n_cmp++;
      if (mem_wr !== 1'b1 || mem_addr !== BASE || mem_data !== 16'h1) begin
         n_fail++;
         $display("FAIL bp_head: wr=%b addr=%h data=%h, required wr=1 addr=%h data=0001",
                  mem_wr, mem_addr, mem_data, BASE);
      end
      repeat (3) step();
      mem_ack = 1'b1;
      wait_done(100);
      for (int i = 0; i < FD; i++) exp_q.push_back({BASE + 20'(i), 16'(i + 1)});
      n_cmp++;
      if (got_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL bp_count: writes=%0d, required %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         n_cmp++;
         if (got_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL bp_write%0d: got %h, required %h", i, got_q[i], exp_q[i]);
         end
      end
      n_cmp++;
      if (done_cnt != 1 || short_frame !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_end: done_pulses=%0d short=%b, required 1 0", done_cnt, short_frame);
      end
   endtask

   task automatic test_short_frame();
      clear_sb();
      mem_ack = 1'b1;
      start_frame();
      n_cmp++;
      if (overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL short_ovf_cleared: ovf=%b, required 0", overflow);
      end
      for (int i = 0; i < 5; i++) begin
         pix_valid = 1'b1;
         pix_data  = 16'hA0 + 16'(i);
         step();
      end
      sof = 1'b1;
      pix_data = 16'hDEAD;
      step();
      sof = 1'b0;
      n_cmp++;
      if (short_frame !== 1'b1) begin
         n_fail++;
         $display("FAIL short_flag: short=%b, required 1", short_frame);
      end
      pix_data = 16'hBEEF;
      repeat (4) step();
      pix_valid = 1'b0;
      wait_done(100);
      for (int i = 0; i < 5; i++) exp_q.push_back({BASE + 20'(i), 16'hA0 + 16'(i)});
      n_cmp++;
      if (got_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL short_count: writes=%0d, required %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         n_cmp++;
         if (got_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL short_write%0d: got %h, required %h", i, got_q[i], exp_q[i]);
         end
      end
      n_cmp++;
      if (done_cnt != 1) begin
         n_fail++;
         $display("FAIL short_done: done_pulses=%0d, required 1", done_cnt);
      end
   endtask

   task automatic test_ignored_inputs();
      clear_sb();
      mem_ack = 1'b1;
      ready = 1'b1;
      step();
      ready = 1'b0;
      n_cmp++;
      if (short_frame !== 1'b0 || state_dbg !== 3'(S_ARM)) begin
         n_fail++;
         $display("FAIL ign_restart: short=%b state=%0d, required short=0 state=%0d",
                  short_frame, state_dbg, 3'(S_ARM));
      end
      pix_valid = 1'b1;
      pix_data  = 16'hEEEE;
      step();
      @(negedge clk);
      n_cmp++;
      if (mem_wr !== 1'b0 || state_dbg !== 3'(S_ARM)) begin
         n_fail++;
         $display("FAIL ign_arm_pixel: wr=%b state=%0d, required wr=0 state=%0d",
                  mem_wr, state_dbg, 3'(S_ARM));
      end
      step();
      sof = 1'b1;
      step();
      sof = 1'b0;
      for (int i = 0; i < FP; i++) begin
         pix_valid = 1'b1;
         pix_data  = 16'h30 + 16'(i);
         ready     = (i == 3);
         step();
      end
      ready = 1'b0;
      pix_valid = 1'b0;
      wait_done(100);
      for (int i = 0; i < FP; i++) exp_q.push_back({BASE + 20'(i), 16'h30 + 16'(i)});
      n_cmp++;
      if (got_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL ign_count: writes=%0d, required %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         n_cmp++;
         if (got_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL ign_write%0d: got %h, required %h", i, got_q[i], exp_q[i]);
         end
      end
      n_cmp++;
      if (done_cnt != 1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL ign_end: done_pulses=%0d busy=%b, required 1 0", done_cnt, busy);
      end
   endtask

   task automatic test_random_stall();
      int cyc = 0;
      int k   = 0;
      clear_sb();
      mem_ack = 1'b1;
      start_frame();
      // ack is forced every other cycle and pixels come every 4th cycle, so nothing overflows
      while (done_cnt == 0 && cyc < 300) begin
         mem_ack = (cyc % 2 == 1) ? 1'b1 : 1'($urandom_range(0, 1));
         if (cyc % 4 == 0 && k < FP) begin
            pix_valid = 1'b1;
            pix_data  = 16'h50 + 16'(k);
            k++;
         end else begin
            pix_valid = 1'b0;
         end
         step();
         cyc++;
      end
      pix_valid = 1'b0;
      mem_ack = 1'b1;
      repeat (3) step();
      for (int i = 0; i < FP; i++) exp_q.push_back({BASE + 20'(i), 16'h50 + 16'(i)});
      n_cmp++;
      if (got_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL stall_count: writes=%0d, required %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         n_cmp++;
         if (got_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL stall_write%0d: got %h, required %h", i, got_q[i], exp_q[i]);
         end
      end
      n_cmp++;
      if (done_cnt != 1 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_end: done_pulses=%0d ovf=%b, required 1 0", done_cnt, overflow);
      end
   endtask

   task automatic test_reset_mid();
      clear_sb();
      mem_ack = 1'b1;
      start_frame();
      for (int i = 0; i < 4; i++) begin
         pix_valid = 1'b1;
         pix_data  = 16'(i + 1);
         step();
      end
      pix_valid = 1'b0;
      n_cmp++;
      if (mem_wr !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_pre: wr=%b, required 1", mem_wr);
      end
      #1;
      reset_n = 1'b0;
      #1;
      n_cmp++;
      if (mem_wr !== 1'b0 || mem_data !== 16'h0 || busy !== 1'b0 || state_dbg !== 3'(S_IDLE)) begin
         n_fail++;
         $display("FAIL rst_async: wr=%b data=%h busy=%b state=%0d, required 0 0000 0 %0d",
                  mem_wr, mem_data, busy, state_dbg, 3'(S_IDLE));
      end
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (6) step();
      for (int i = 0; i < 3; i++) exp_q.push_back({BASE + 20'(i), 16'(i + 1)});
      n_cmp++;
      if (got_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL rst_count: writes=%0d, required %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         n_cmp++;
         if (got_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL rst_write%0d: got %h, required %h", i, got_q[i], exp_q[i]);
         end
      end
      n_cmp++;
      if (done_cnt != 0 || mem_wr !== 1'b0 || mem_addr !== BASE) begin
         n_fail++;
         $display("FAIL rst_after: done_pulses=%0d wr=%b addr=%h, required 0 0 %h",
                  done_cnt, mem_wr, mem_addr, BASE);
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_backpressure();
      test_short_frame();
      test_ignored_inputs();
      test_random_stall();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/photo_capture.md
PHOTO_CAPTURE -- requirements
Module: photo_capture

Interface
REQ-001 SHALL have parameter FRAME_PIXELS, default 307200, meaning pixels per captured frame (640x480).
REQ-002 SHALL have parameter ADDR_W, default 20, meaning width of the memory word address.
REQ-003 SHALL have parameter BASE_ADDR, default 0, meaning the address of the first pixel written.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, meaning pixel buffer entries (power of 2).
REQ-005 clk  in  1  system clock; all signals synchronous to it.
REQ-006 reset_n  in  1  reset, asynchronous, active-low.
REQ-007 ready  in  1  one-cycle capture request from the delay stage.
REQ-008 sof  in  1  one-cycle start-of-frame strobe from the camera front end, already in the clk domain.
REQ-009 pix_valid  in  1  pixel strobe.
REQ-010 pix_data  in  16  RGB565 pixel.
REQ-011 mem_wr  out  1  write request.
REQ-012 mem_addr  out  ADDR_W  write address.
REQ-013 mem_data  out  16  write data.
REQ-014 mem_ack  in  1  write accepted.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle completion pulse.
REQ-017 overflow  out  1  sticky: at least one pixel was dropped.
REQ-018 short_frame  out  1  sticky: sof arrived before FRAME_PIXELS pixels were accepted.

Function
REQ-019 The FSM SHALL have states IDLE, ARM, CAPTURE, DRAIN and DONE.
REQ-020 IDLE -> ARM on ready=1; this transition also clears overflow, short_frame, the pixel count, and sets the write address to BASE_ADDR.
REQ-021 ready SHALL be ignored in every state except IDLE.
REQ-022 ARM -> CAPTURE on sof=1; pix_valid SHALL be ignored in ARM and in the sof cycle itself.
REQ-023 In CAPTURE, each pix_valid cycle SHALL increment the pixel count; the pixel SHALL be pushed to the FIFO iff the FIFO was not full at the start of that cycle, otherwise it is dropped and overflow is set.
REQ-024 A push and a pop SHALL be allowed in the same cycle; a full FIFO SHALL reject the push even if a pop occurs that cycle.
REQ-025 CAPTURE -> DRAIN in the cycle in which the count reaches FRAME_PIXELS.
REQ-026 If sof=1 in CAPTURE before the count reaches FRAME_PIXELS, the FSM SHALL set short_frame and go to DRAIN, ignoring any pix_valid in that cycle.
REQ-027 pix_valid SHALL be ignored in DRAIN, DONE and IDLE.
REQ-028 DRAIN -> DONE when the FIFO is empty and no write is outstanding.
REQ-029 DONE SHALL assert done for exactly one cycle, then go to IDLE.
REQ-030 mem_wr SHALL be high whenever the FIFO is non-empty in ARM, CAPTURE or DRAIN, presenting the FIFO head on mem_data and the current address on mem_addr.
REQ-031 mem_addr and mem_data SHALL be held stable while mem_wr=1 and mem_ack=0.
REQ-032 On mem_wr=1 and mem_ack=1, the FSM SHALL pop the FIFO and increment mem_addr by 1; mem_addr wraps modulo 2^ADDR_W.
REQ-033 Writes SHALL be packed: dropped pixels consume no address.
REQ-034 Minimum latency SHALL be: a pixel accepted in cycle t appears on mem_wr in cycle t+1.
REQ-035 mem_ack while mem_wr=0 SHALL be ignored.
REQ-036 The pixel counter SHALL be wide enough for FRAME_PIXELS: $clog2(FRAME_PIXELS+1) bits.

Reset
REQ-037 On reset_n=0, asynchronously: state=IDLE, FIFO empty, count=0, mem_addr=BASE_ADDR, and mem_wr, mem_data, busy, done, overflow and short_frame all 0.
REQ-038 Reset mid-capture SHALL abandon the frame; no further writes occur until a new ready arrives.

Structure
REQ-039 The capture state enum and the default FRAME_PIXELS constant SHALL live in shared package capture_pkg.
REQ-040 The FIFO SHALL be a sub-module named pixel_fifo (parameterised depth/width, full/empty flags, async active-low reset).

Verification (bench uses FRAME_PIXELS=8, FIFO_DEPTH=4, BASE_ADDR=0x100)
REQ-041 Nominal: ready, sof, 8 pix_valid with data 1..8, mem_ack tied 1 -> writes at 0x100..0x107 with data 1..8; one done pulse; overflow=0 and short_frame=0.
REQ-042 Backpressure: mem_ack=0 throughout a burst of 8 consecutive pixels -> first 4 buffered, pixels 5..8 dropped, overflow=1; after ack released, exactly 4 writes (data 1..4) then done.
REQ-043 Short frame: sof after 5 pixels -> short_frame=1, 5 writes at 0x100..0x104, done; pix_valid arriving after that sof causes no write.
REQ-044 Ignored inputs: ready pulsed during CAPTURE and pix_valid during ARM -> no effect on count or address; a second ready after done restarts at 0x100 with flags cleared.
REQ-045 Reset mid-operation: assert reset_n=0 after 3 writes with mem_wr high -> mem_wr falls without waiting for a clock edge; state IDLE; no done pulse.
REQ-046 Handshake hold: random mem_ack stalls -> mem_addr and mem_data remain stable while mem_wr=1 and mem_ack=0 (assertion checked every cycle).
